ks_mw_add_seq: RTL

- Multi-word add/subtract sequencer wrapped around a 32-bit Kogge-Stone adder core.
- Accepts a stream of 32-bit operand word pairs, least-significant word first, over a valid/ready handshake.
- Chains the carry between beats and emits one registered 32-bit sum word per accepted beat.
- Sits downstream of the operand source and upstream of result consumers.
- Extends the carry-in-less prefix adder to arbitrary-width operands and subtraction.

---
 rtl/ks_mw_pkg.sv | 25 ++
 rtl/ks_add32_cin.sv | 59 +++++
 rtl/ks_mw_add_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ks_mw_pkg.sv
// ks_mw_pkg: shared types and constants for the multi-word Kogge-Stone add/subtract sequencer.
//   WORD_W  - datapath word width
//   IDX_W   - width of the per-operation word index
//   state_e - sequencer state
//   beat_t  - one registered result beat
package ks_mw_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] sum;
        logic [IDX_W-1:0]  idx;
        logic              last;
        logic              carry;
        logic              ovf;
        logic              err;
    } beat_t;

endpackage

// File: rtl/ks_add32_cin.sv
// ks_add32_cin: combinational 32-bit Kogge-Stone adder with carry-in.
//   a, b  - operands
//   cin   - carry into bit 0
//   sum   - a + b + cin (low 32 bits)
//   cout  - carry out of bit 31
//   c31   - carry into bit 31 (for signed-overflow detection)
module ks_add32_cin
    import ks_mw_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout,
    output logic              c31
);

    localparam int unsigned Levels = $clog2(WORD_W);

    // Black cell: combines generate and propagate of two adjacent groups.
    function automatic logic [1:0] black_cell(logic gh, logic ph, logic gl, logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    // Grey cell: group reaches bit 0, so only the generate is needed.
    function automatic logic grey_cell(logic gh, logic ph, logic gl);
        return gh | (ph & gl);
    endfunction

    logic [WORD_W-1:0] p0;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;

    always_comb begin
        // pg cells
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        // Fold cin into bit 0's generate so every prefix ending at bit 0 includes it.
        g[0] = g[0] | (p0[0] & cin);
        for (int lvl = 0; lvl < int'(Levels); lvl++) begin
            // Walk downward so g[i-dist]/p[i-dist] still hold the previous level.
            for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
                if (i >= (2 << lvl)) begin
                    {g[i], p[i]} = black_cell(g[i], p[i], g[i-(1<<lvl)], p[i-(1<<lvl)]);
                end else if (i >= (1 << lvl)) begin
                    g[i] = grey_cell(g[i], p[i], g[i-(1<<lvl)]);
                end
                // Lower positions are buffer cells: value passes through unchanged.
            end
        end
    end

    // g[i] is now the carry out of bit i.
    assign sum  = p0 ^ {g[WORD_W-2:0], cin};
    assign cout = g[WORD_W-1];
    assign c31  = g[WORD_W-2];

endmodule

// File: rtl/ks_mw_add_seq.sv
// ks_mw_add_seq: multi-word add/subtract sequencer around a 32-bit Kogge-Stone core.
// Operand words arrive least-significant first; the carry is chained between beats and
// one registered sum word is emitted per accepted beat (1-cycle latency).
//   clk, rst_n                - clock, async active-low reset
//   in_valid/in_ready         - operand handshake
//   in_a, in_b                - operand words
//   in_first, in_last, in_sub - operation framing and subtract select (first beat)
//   out_valid/out_ready       - result handshake
//   out_sum, out_idx          - result word and its index within the operation
//   out_last, out_carry       - final-word flag, carry out of this word
//   out_ovf, out_err          - signed overflow (last beat only), sequencing error
//   ops_done                  - completed-operation counter (wraps)
module ks_mw_add_seq
    import ks_mw_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              out_err,
    output logic [CNT_W-1:0]  ops_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(MAX_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    beat_t             out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  ops_q, ops_d;

    logic              accept;
    logic              start;
    logic              seq_err;
    logic              sub_eff;
    logic              cin;
    logic [WORD_W-1:0] b_eff;
    logic [IDX_W-1:0]  idx_cur;
    logic              forced;
    logic              last;
    logic [WORD_W-1:0] sum;
    logic              cout;
    logic              c31;

    // Single output register: a new beat may enter whenever the held one leaves.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // Any beat in IDLE, or an in_first beat in ACTIVE, is treated as a first beat.
        start   = (state_q == StIdle) || in_first;
        seq_err = (state_q == StIdle) ? !in_first : in_first;
        sub_eff = start ? in_sub : sub_q;
        cin     = start ? in_sub : carry_q;
        b_eff   = sub_eff ? ~in_b : in_b;
        idx_cur = start ? '0 : idx_q;
        forced  = !start && (idx_q == LastIdx) && !in_last;
        last    = in_last || forced;
    end

    ks_add32_cin u_add (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .c31  (c31)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ops_d       = ops_q;
        if (accept) begin
            state_d     = last ? StIdle : StActive;
            idx_d       = idx_cur + IDX_W'(1);
            carry_d     = cout;
            sub_d       = sub_eff;
            out_valid_d = 1'b1;
            out_d.sum   = sum;
            out_d.idx   = idx_cur;
            out_d.last  = last;
            out_d.carry = cout;
            out_d.ovf   = last & (c31 ^ cout);
            out_d.err   = seq_err | forced;
            if (last) begin
                ops_d = ops_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ops_q       <= ops_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_q.sum;
    assign out_idx   = out_q.idx;
    assign out_last  = out_q.last;
    assign out_carry = out_q.carry;
    assign out_ovf   = out_q.ovf;
    assign out_err   = out_q.err;
    assign ops_done  = ops_q;

endmodule
